// File: rtl/mips_debug_pkg.sv
// Shared debug-path definitions: UART command bytes and run-controller state encoding.
package mips_debug_pkg;

    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_NEXT = 8'h6E;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        STEP_WAIT  = 3'd2,
        STEP_PULSE = 3'd3,
        DUMP       = 3'd4,
        DONE       = 3'd5
    } run_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_run_controller.sv
// Run/step sequencer for the PC and pipeline enables, with halt-triggered dump and cycle count.
module pc_run_controller #(
    parameter int unsigned CYCLE_W  = 32,
    parameter logic [7:0]  CMD_CONT = mips_debug_pkg::CMD_CONT,
    parameter logic [7:0]  CMD_STEP = mips_debug_pkg::CMD_STEP,
    parameter logic [7:0]  CMD_NEXT = mips_debug_pkg::CMD_NEXT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [7:0]         cmd_code,
    input  logic               halt_detected,
    input  logic               dump_ack,
    output logic               pipe_enable,
    output logic               dump_req,
    output logic               step_mode,
    output logic               halted,
    output logic [CYCLE_W-1:0] cycle_count
);

    import mips_debug_pkg::*;

    run_state_e state_q;
    run_state_e state_n;
    logic       final_q;
    logic       final_n;
    logic       step_n;

    // State, final-run flag and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            final_q     <= 1'b0;
            pipe_enable <= 1'b0;
            dump_req    <= 1'b0;
            step_mode   <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_n;
            final_q     <= final_n;
            pipe_enable <= (state_n == RUN) || (state_n == STEP_PULSE);
            dump_req    <= (state_n == DUMP);
            step_mode   <= step_n;
            halted      <= (state_n == DONE);
        end
    end

    // Next-state logic; halt is only looked at in RUN and STEP_PULSE, ack only in DUMP.
    always_comb begin
        state_n = state_q;
        final_n = final_q;
        step_n  = step_mode;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && (cmd_code == CMD_CONT)) begin
                    state_n = RUN;
                end else if (cmd_valid && (cmd_code == CMD_STEP)) begin
                    state_n = STEP_WAIT;
                    step_n  = 1'b1;
                end
            end
            RUN: begin
                if (halt_detected) begin
                    state_n = DUMP;
                    final_n = 1'b1;
                end
            end
            STEP_WAIT: begin
                if (cmd_valid && (cmd_code == CMD_NEXT)) begin
                    state_n = STEP_PULSE;
                end
            end
            STEP_PULSE: begin
                state_n = DUMP;
                if (halt_detected) begin
                    final_n = 1'b1;
                end
            end
            DUMP: begin
                if (dump_ack) begin
                    state_n = final_q ? DONE : STEP_WAIT;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Executed-cycle counter: one count per enabled cycle, cleared only by reset.
    sat_counter #(
        .W(CYCLE_W)
    ) u_cycle_counter (
        .clock(clock),
        .clear(reset),
        .inc  (pipe_enable),
        .count(cycle_count)
    );

endmodule

// File: tb/tb_pc_run_controller.sv
// Bench for pc_run_controller: a 32-bit and a 4-bit counter instance share one stimulus stream.
module tb_pc_run_controller;

    import mips_debug_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_code = 8'h00;
    logic        halt_detected = 1'b0;
    logic        dump_ack = 1'b0;

    logic        pe_a, dr_a, sm_a, ht_a;
    logic [31:0] cc_a;
    logic        pe_b, dr_b, sm_b, ht_b;
    logic [3:0]  cc_b;

    int checks = 0;
    int failures = 0;
    int en_cycles = 0;

    pc_run_controller #(.CYCLE_W(32)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .halt_detected(halt_detected), .dump_ack(dump_ack),
        .pipe_enable(pe_a), .dump_req(dr_a), .step_mode(sm_a), .halted(ht_a),
        .cycle_count(cc_a)
    );

    pc_run_controller #(.CYCLE_W(4)) dut4 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .halt_detected(halt_detected), .dump_ack(dump_ack),
        .pipe_enable(pe_b), .dump_req(dr_b), .step_mode(sm_b), .halted(ht_b),
        .cycle_count(cc_b)
    );

    always #5 clock = ~clock;

    // Behavioural model: activity flags describing what the sequencer is doing.
    bit          m_running = 0, m_waiting = 0, m_pulsing = 0, m_dumping = 0;
    bit          m_finished = 0, m_last = 0, m_stepping = 0;
    logic [31:0] m_cnt = 0;
    logic [3:0]  m_cnt4 = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_running <= 0; m_waiting <= 0; m_pulsing <= 0; m_dumping <= 0;
            m_finished <= 0; m_last <= 0; m_stepping <= 0;
            m_cnt <= 0; m_cnt4 <= 0;
        end else begin
            if (m_running || m_pulsing) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
                if (m_cnt4 != 4'hF) m_cnt4 <= m_cnt4 + 1;
            end
            if (m_finished) begin
                m_finished <= 1;
            end else if (m_running) begin
                if (halt_detected) begin
                    m_running <= 0; m_dumping <= 1; m_last <= 1;
                end
            end else if (m_pulsing) begin
                m_pulsing <= 0; m_dumping <= 1;
                if (halt_detected) m_last <= 1;
            end else if (m_dumping) begin
                if (dump_ack) begin
                    m_dumping <= 0;
                    if (m_last) m_finished <= 1; else m_waiting <= 1;
                end
            end else if (m_waiting) begin
                if (cmd_valid && cmd_code == CMD_NEXT) begin
                    m_waiting <= 0; m_pulsing <= 1;
                end
            end else if (cmd_valid && cmd_code == CMD_CONT) begin
                m_running <= 1;
            end else if (cmd_valid && cmd_code == CMD_STEP) begin
                m_waiting <= 1; m_stepping <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clock) begin
        if (pe_a) en_cycles++;
        chk("pipe_enable", 64'(pe_a), 64'(m_running || m_pulsing));
        chk("dump_req", 64'(dr_a), 64'(m_dumping));
        chk("step_mode", 64'(sm_a), 64'(m_stepping));
        chk("halted", 64'(ht_a), 64'(m_finished));
        chk("cycle_count", 64'(cc_a), 64'(m_cnt));
        chk("w4_pipe_enable", 64'(pe_b), 64'(m_running || m_pulsing));
        chk("w4_dump_req", 64'(dr_b), 64'(m_dumping));
        chk("w4_cycle_count", 64'(cc_b), 64'(m_cnt4));
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cmd_valid = 0;
        halt_detected = 0;
        dump_ack = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] code);
        cmd_valid = 1;
        cmd_code = code;
        tick();
    endtask

    task automatic do_reset();
        reset = 1;
        ticks(2);
        reset = 0;
        en_cycles = 0;
    endtask

    initial begin
        do_reset();
        @(negedge clock);
        chk("reset_pe", 64'(pe_a), 64'(0));
        chk("reset_cnt", 64'(cc_a), 64'(0));

        // Continuous run; stray ack in IDLE and RUN, commands in RUN ignored.
        dump_ack = 1; tick();
        send(8'h41);
        send(CMD_CONT);
        ticks(3);
        send(CMD_STEP);
        send(CMD_NEXT);
        dump_ack = 1; tick();
        ticks(4);
        halt_detected = 1; tick();
        @(negedge clock);
        chk("t1_dump_req", 64'(dr_a), 64'(1));
        chk("t1_en_cycles", 64'(en_cycles), 64'(11));
        ticks(2);
        dump_ack = 1; tick();
        @(negedge clock);
        chk("t1_halted", 64'(ht_a), 64'(1));
        chk("t1_count", 64'(cc_a), 64'(11));

        // Step mode: three steps, CMD_CONT ignored while waiting.
        do_reset();
        send(CMD_STEP);
        send(CMD_CONT);
        for (int s = 0; s < 3; s++) begin
            send(CMD_NEXT);
            tick();
            tick();
            dump_ack = 1; tick();
        end
        @(negedge clock);
        chk("t2_count", 64'(cc_a), 64'(3));
        chk("t2_step_mode", 64'(sm_a), 64'(1));
        chk("t2_halted", 64'(ht_a), 64'(0));
        chk("t2_en_cycles", 64'(en_cycles), 64'(3));

        // Halt during the second step pulse ends the run.
        do_reset();
        send(CMD_STEP);
        send(CMD_NEXT);
        tick();
        dump_ack = 1; tick();
        send(CMD_NEXT);
        halt_detected = 1; tick();
        dump_ack = 1; tick();
        send(CMD_NEXT);
        ticks(3);
        @(negedge clock);
        chk("t3_halted", 64'(ht_a), 64'(1));
        chk("t3_en_cycles", 64'(en_cycles), 64'(2));
        chk("t3_count", 64'(cc_a), 64'(2));

        // Reset in the middle of a dump.
        do_reset();
        send(CMD_CONT);
        ticks(2);
        halt_detected = 1; tick();
        tick();
        reset = 1; tick();
        @(negedge clock);
        chk("t4_dump_req", 64'(dr_a), 64'(0));
        chk("t4_count", 64'(cc_a), 64'(0));
        chk("t4_pe", 64'(pe_a), 64'(0));
        reset = 0;

        // Long run: the 4-bit counter saturates at 15.
        do_reset();
        send(CMD_CONT);
        ticks(20);
        halt_detected = 1; tick();
        dump_ack = 1; tick();
        @(negedge clock);
        chk("t5_count4", 64'(cc_b), 64'(15));
        chk("t5_count32", 64'(cc_a), 64'(21));
        chk("t5_halted4", 64'(ht_b), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
